// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT timer-arming block.
//   - CLINT register offsets relative to the CLINT base address
//   - sequencer state encoding
//   - bus command bundle handed from the sequencer to the transfer engine
//   - default per-transfer timeout
package clint_pkg;

  localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [3:0] {
    IDLE,
    RD_HI0,
    RD_LO,
    RD_HI1,
    CALC,
    WR_HI_MAX,
    WR_LO,
    WR_HI,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_cmd_t;

endpackage

// File: rtl/clint_bus_xfer.sv
// Single bus transfer engine with per-transfer timeout.
//   start      in   one-cycle pulse; launches cmd when no transfer is active
//   cmd        in   we/addr/wdata of the transfer to launch
//   bus_*      out  request held stable until bus_ready is sampled high
//   bus_ready  in   responder completion
//   bus_rdata  in   read data, valid with bus_ready
//   ack        out  combinational: the current edge completes the transfer
//   timeout    out  combinational: the current edge expires the transfer
//   rdata      out  read data to capture on the ack edge
module clint_bus_xfer
  import clint_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  xfer_cmd_t   cmd,
  output logic        bus_en,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        ack,
  output logic        timeout,
  output logic [31:0] rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  // Counts completed bus_en cycles without bus_ready; cleared at launch.
  logic [CW-1:0] cnt;

  assign ack     = bus_en & bus_ready;
  assign timeout = bus_en & ~bus_ready & (cnt == LAST);
  assign rdata   = bus_rdata;

  // NOTE: state is updated with non-blocking assignments only, and the
  // async reset branch clears bus_en immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_en    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cnt       <= '0;
    end else if (start && !bus_en) begin
      bus_en    <= 1'b1;
      bus_we    <= cmd.we;
      bus_addr  <= cmd.addr;
      bus_wdata <= cmd.wdata;
      cnt       <= '0;
    end else if (bus_en) begin
      if (bus_ready || cnt == LAST) begin
        bus_en <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clint_arm_ctrl.sv
// Arms the CLINT timer: reads MTIME (hi/lo/hi with rollover retry), adds a
// delta, and writes MTIMECMP as hi=max, lo, hi so no spurious interrupt can
// fire while the 64-bit compare value is half written.
//   arm_req/arm_delta  in   start a sequence with a new delta
//   periodic_en        in   re-arm on each timer_irq rising edge
//   timer_irq          in   CLINT timer interrupt level
//   bus_*              out/in  simple request/ready bus
//   busy/done/err      out  sequence status; done/err are one-cycle pulses
//   cmp_value          out  last computed MTIMECMP value
module clint_arm_ctrl
  import clint_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE  = 32'h0200_0000,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm_req,
  input  logic [31:0] arm_delta,
  input  logic        periodic_en,
  input  logic        timer_irq,
  output logic        bus_en,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] cmp_value
);

  localparam logic [31:0] A_MTIME_LO = CLINT_BASE + MTIME_LO_OFF;
  localparam logic [31:0] A_MTIME_HI = CLINT_BASE + MTIME_HI_OFF;
  localparam logic [31:0] A_CMP_LO   = CLINT_BASE + MTIMECMP_LO_OFF;
  localparam logic [31:0] A_CMP_HI   = CLINT_BASE + MTIMECMP_HI_OFF;

  state_t      state;
  logic [31:0] delta_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        irq_q;
  logic        xfer_start;
  xfer_cmd_t   xfer_cmd;
  logic        xfer_ack;
  logic        xfer_to;
  logic [31:0] xfer_rdata;
  logic        per_trig;

  assign per_trig = periodic_en & timer_irq & ~irq_q;

  clint_bus_xfer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_xfer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (xfer_start),
    .cmd      (xfer_cmd),
    .bus_en   (bus_en),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .ack      (xfer_ack),
    .timeout  (xfer_to),
    .rdata    (xfer_rdata)
  );

  // A launch is a registered one-cycle start pulse, so the engine raises
  // bus_en one cycle after the previous ack: that cycle is the idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      delta_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      irq_q      <= 1'b0;
      xfer_start <= 1'b0;
      xfer_cmd   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmp_value  <= '0;
    end else begin
      xfer_start <= 1'b0;
      irq_q      <= timer_irq;
      if (xfer_to) begin
        state <= ERR;
        err   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (arm_req || per_trig) begin
              if (arm_req) delta_q <= arm_delta;
              busy       <= 1'b1;
              xfer_start <= 1'b1;
              xfer_cmd   <= '{we: 1'b0, addr: A_MTIME_HI, wdata: 32'h0};
              state      <= RD_HI0;
            end
          end
          RD_HI0: if (xfer_ack) begin
            hi_q       <= xfer_rdata;
            xfer_start <= 1'b1;
            xfer_cmd   <= '{we: 1'b0, addr: A_MTIME_LO, wdata: 32'h0};
            state      <= RD_LO;
          end
          RD_LO: if (xfer_ack) begin
            lo_q       <= xfer_rdata;
            xfer_start <= 1'b1;
            xfer_cmd   <= '{we: 1'b0, addr: A_MTIME_HI, wdata: 32'h0};
            state      <= RD_HI1;
          end
          RD_HI1: if (xfer_ack) begin
            if (xfer_rdata != hi_q) begin
              // lo rolled over between the hi reads; re-read lo under new hi
              hi_q       <= xfer_rdata;
              xfer_start <= 1'b1;
              xfer_cmd   <= '{we: 1'b0, addr: A_MTIME_LO, wdata: 32'h0};
              state      <= RD_LO;
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
            cmp_value  <= {hi_q, lo_q} + {32'h0, delta_q};
            xfer_start <= 1'b1;
            xfer_cmd   <= '{we: 1'b1, addr: A_CMP_HI, wdata: 32'hFFFF_FFFF};
            state      <= WR_HI_MAX;
          end
          WR_HI_MAX: if (xfer_ack) begin
            xfer_start <= 1'b1;
            xfer_cmd   <= '{we: 1'b1, addr: A_CMP_LO, wdata: cmp_value[31:0]};
            state      <= WR_LO;
          end
          WR_LO: if (xfer_ack) begin
            xfer_start <= 1'b1;
            xfer_cmd   <= '{we: 1'b1, addr: A_CMP_HI, wdata: cmp_value[63:32]};
            state      <= WR_HI;
          end
          WR_HI: if (xfer_ack) begin
            done  <= 1'b1;
            state <= DONE;
          end
          DONE: begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          ERR: begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/clint_arm_ctrl.md
CLINT_ARM_CTRL -- requirements
Module: clint_arm_ctrl

Interface
REQ-001 Parameter CLINT_BASE, default 32'h0200_0000: CLINT base address. MTIMECMP lo/hi = base+0x4000/+0x4004; MTIME lo/hi = base+0xBFF8/+0xBFFC.
REQ-002 Parameter TIMEOUT_CYC, default 64: maximum cycles to wait for bus_ready per transfer.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 arm_req  in  1  one-cycle pulse; start an arm sequence with arm_delta.
REQ-006 arm_delta  in  32  interval in mtime ticks; sampled on an accepted arm_req.
REQ-007 periodic_en  in  1  when 1, a rising edge of timer_irq re-arms with the stored delta.
REQ-008 timer_irq  in  1  CLINT timer interrupt level.
REQ-009 bus_en  out  1  transfer request.
REQ-010 bus_we  out  1  1 = write, 0 = read.
REQ-011 bus_addr  out  32  transfer address.
REQ-012 bus_wdata  out  32  write data.
REQ-013 bus_rdata  in  32  read data; valid when bus_ready = 1.
REQ-014 bus_ready  in  1  responder completion.
REQ-015 busy  out  1  high from sequence start until done or err.
REQ-016 done  out  1  one-cycle pulse: MTIMECMP fully written.
REQ-017 err  out  1  one-cycle pulse: transfer timed out; sequence aborted.
REQ-018 cmp_value  out  64  last MTIMECMP value computed.

Function
REQ-019 Bus handshake: drive bus_en=1 with bus_we, bus_addr and bus_wdata stable. Hold them until a rising edge samples bus_ready=1. Drop bus_en the next cycle. Insert one idle cycle (bus_en=0) between transfers.
REQ-020 Read data is captured on the edge that samples bus_ready=1.
REQ-021 States: IDLE, RD_HI0, RD_LO, RD_HI1, CALC, WR_HI_MAX, WR_LO, WR_HI, DONE, ERR.
REQ-022 IDLE -> RD_HI0 on arm_req, or on a timer_irq rising edge when periodic_en=1. The delta is latched in that cycle; a periodic trigger reuses the last latched delta.
REQ-023 RD_HI0 -> RD_LO -> RD_HI1 reads MTIME hi, lo, hi.
REQ-024 If the second hi read differs from the first, return to RD_LO once more with hi := the second value (rollover handling). Otherwise go to CALC.
REQ-025 CALC (1 cycle): cmp_value = {hi,lo} + zero-extended delta; 64-bit unsigned; wraps modulo 2^64.
REQ-026 WR_HI_MAX writes 32'hFFFF_FFFF to MTIMECMP hi.
REQ-027 WR_LO writes cmp_value[31:0] to MTIMECMP lo.
REQ-028 WR_HI writes cmp_value[63:32] to MTIMECMP hi, then goes to DONE.
REQ-029 DONE pulses done for 1 cycle, then returns to IDLE.
REQ-030 arm_req or a periodic trigger while busy=1 is ignored; no queueing.
REQ-031 A per-transfer timeout counter starts at the first cycle of bus_en. If TIMEOUT_CYC cycles pass without bus_ready, drop bus_en and go to ERR.
REQ-032 ERR pulses err for 1 cycle, then returns to IDLE; no further writes are issued.
REQ-033 arm_delta = 0 is legal: cmp_value equals the mtime read, and the irq fires immediately.
REQ-034 A timer_irq rising edge is detected against a registered copy of timer_irq.
REQ-035 When arm_req and a periodic trigger occur in the same cycle, arm_req wins and its delta is latched.

Reset
REQ-036 Reset values:
- bus_en, bus_we, busy, done, err = 0
- bus_addr, bus_wdata = 0
- cmp_value = 0
- stored delta = 0
- state = IDLE
- registered timer_irq = 0
REQ-037 Reset asserted mid-transfer drops bus_en asynchronously. The sequence is not resumed after reset.

Structure
REQ-038 A shared package clint_pkg holds:
- CLINT register offsets (MTIMECMP_LO/HI, MTIME_LO/HI)
- the state enum
- the default TIMEOUT_CYC
REQ-039 One sub-module, clint_bus_xfer, is natural. It executes a single read or write with the handshake (REQ-019, REQ-020) and the timeout (REQ-031). The sequencer FSM instantiates it once.

Verification
REQ-040 Arm, no rollover: CLINT model with mtime=100, arm_delta=20. Required bus order:
- read 0x0200BFFC, read 0x0200BFF8, read 0x0200BFFC
- write 0x02004004 = FFFFFFFF, write 0x02004000 = 120, write 0x02004004 = 0
Then done pulses once and cmp_value = 120.
REQ-041 Rollover: mtime reads hi=0, lo=FFFFFFFF, hi=1. The block re-reads lo (lo=3). Final writes: lo = 3+delta, hi = 1.
REQ-042 Periodic: periodic_en=1, delta=1000. Each timer_irq rise produces a new MTIMECMP equal to the mtime read + 1000. Check two consecutive periods.
REQ-043 Wait states: bus_ready delayed 5 cycles on every transfer. Bus signals stay stable while waiting, one idle cycle separates transfers, and the result is correct.
REQ-044 Timeout: bus_ready held 0 and TIMEOUT_CYC=8. err pulses 8 cycles after bus_en rises, no write is issued, and busy falls.
REQ-045 Busy collision plus mid-sequence reset:
- arm_req during WR_LO is ignored.
- Reset asserted in WR_LO drops bus_en at once.
- After reset the block is in IDLE with all outputs 0.
